// File: rtl/ppu_oam_dma.sv
// OAM DMA engine: copies CPU page $XX00-$XXFF to OAM through $2004 while the CPU is halted.
// Define PPU_OAM_DMA_ALIGN_EN to align the first read to an even cycle (adds the ALIGN state).
module ppu_oam_dma (
    input  logic        i_cpu_clk,
    input  logic        i_cpu_rstn,
    input  logic [15:0] i_bus_addr,
    input  logic        i_bus_wn,
    input  logic [7:0]  i_bus_wdata,
    input  logic [7:0]  i_bus_rdata,
    output logic [15:0] o_dma_addr,
    output logic        o_dma_wn,
    output logic [7:0]  o_dma_wdata,
    output logic        o_dma_active,
    output logic        o_cpu_halt,
    output logic        o_dma_done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HALT  = 3'd1;
    localparam logic [2:0] S_ALIGN = 3'd2;
    localparam logic [2:0] S_RD    = 3'd3;
    localparam logic [2:0] S_WR    = 3'd4;

    localparam logic [15:0] OAMDATA_ADDR = 16'h2004;
    localparam logic [15:0] TRIGGER_ADDR = 16'h4014;

    logic [2:0] r_state;
    logic [2:0] w_state_next;
    logic [7:0] r_page;
    logic [7:0] r_idx;
    logic [7:0] r_data;
    logic       r_done;
    logic       w_trigger;
    logic       w_last;
    logic [2:0] w_after_halt;

    assign w_trigger = (i_bus_addr == TRIGGER_ADDR) && !i_bus_wn;
    assign w_last    = (r_idx == 8'hFF);

`ifdef PPU_OAM_DMA_ALIGN_EN
    // Free-running parity; reads must start on an even (r_par==0) cycle.
    logic r_par;

    always_ff @(posedge i_cpu_clk or negedge i_cpu_rstn) begin
        if (!i_cpu_rstn) begin
            r_par <= 1'b0;
        end else begin
            r_par <= ~r_par;
        end
    end

    assign w_after_halt = r_par ? S_RD : S_ALIGN;
`else
    assign w_after_halt = S_RD;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_trigger) w_state_next = S_HALT;
            S_HALT:  w_state_next = w_after_halt;
`ifdef PPU_OAM_DMA_ALIGN_EN
            S_ALIGN: w_state_next = S_RD;
`endif
            S_RD:    w_state_next = S_WR;
            S_WR:    w_state_next = w_last ? S_IDLE : S_RD;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_cpu_clk or negedge i_cpu_rstn) begin
        if (!i_cpu_rstn) begin
            r_state <= S_IDLE;
            r_page  <= 8'h00;
            r_idx   <= 8'h00;
            r_data  <= 8'h00;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= (r_state == S_WR) && w_last;
            if (r_state == S_IDLE && w_trigger) begin
                r_page <= i_bus_wdata;
                r_idx  <= 8'h00;
            end
            if (r_state == S_RD) begin
                r_data <= i_bus_rdata;
            end
            // Index never rolls into the next page: the final write returns to IDLE instead.
            if (r_state == S_WR && !w_last) begin
                r_idx <= r_idx + 8'd1;
            end
        end
    end

    always_comb begin
        o_dma_addr   = 16'h0000;
        o_dma_wn     = 1'b1;
        o_dma_wdata  = 8'h00;
        o_dma_active = (r_state != S_IDLE);
        o_cpu_halt   = (r_state != S_IDLE);
        o_dma_done   = r_done;
        case (r_state)
            S_RD: begin
                o_dma_addr = {r_page, r_idx};
            end
            S_WR: begin
                o_dma_addr  = OAMDATA_ADDR;
                o_dma_wn    = 1'b0;
                o_dma_wdata = r_data;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ppu_oam_dma.sv
// Directed bench for ppu_oam_dma: full transfers, parity alignment, page $FF, ignored retrigger, mid-transfer reset.
`timescale 1ns/1ps
module tb_ppu_oam_dma;

    logic        clk;
    logic        rstn;
    logic [15:0] bus_addr;
    logic        bus_wn;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic [15:0] dma_addr;
    logic        dma_wn;
    logic [7:0]  dma_wdata;
    logic        dma_active;
    logic        cpu_halt;
    logic        dma_done;
    logic        par_m;
    int          n_checks = 0;
    int          n_errors = 0;

    ppu_oam_dma dut (
        .i_cpu_clk   (clk),
        .i_cpu_rstn  (rstn),
        .i_bus_addr  (bus_addr),
        .i_bus_wn    (bus_wn),
        .i_bus_wdata (bus_wdata),
        .i_bus_rdata (bus_rdata),
        .o_dma_addr  (dma_addr),
        .o_dma_wn    (dma_wn),
        .o_dma_wdata (dma_wdata),
        .o_dma_active(dma_active),
        .o_cpu_halt  (cpu_halt),
        .o_dma_done  (dma_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] mem_val(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    assign bus_rdata = mem_val(dma_active ? dma_addr : bus_addr);

    // Expected cycle parity: toggles on every edge out of reset.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) par_m <= 1'b0;
        else       par_m <= ~par_m;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic bus_idle();
        bus_addr  = 16'h0000;
        bus_wn    = 1'b1;
        bus_wdata = 8'h00;
    endtask

    task automatic bus_trig(input logic [7:0] page);
        bus_addr  = 16'h4014;
        bus_wn    = 1'b0;
        bus_wdata = page;
    endtask

    task automatic check_reset_outs(input string tag);
        check(tag, {dma_addr, dma_wn, dma_wdata, dma_active, cpu_halt, dma_done},
              {16'h0000, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0});
    endtask

    // Runs one transfer, sampling on falling edges. want_par selects the parity of the HALT cycle.
    task automatic run_xfer(input logic [7:0] page, input bit want_par, input bit skip_trig,
                            input bit inject, input int abort_wr,
                            input bit chain, input logic [7:0] chain_page);
        int len = 0, rd_n = 0, wr_n = 0, rd_bad = 0, wr_bad = 0, done_n = 0, exp_len;
        int first_rd_len = 0;
        logic first_rd_par = 1'b1;
        bit seen_rd = 0;
        logic halt_par;
        if (!skip_trig) begin
            @(negedge clk);
            while (par_m == want_par) @(negedge clk);
            bus_trig(page);
        end
        @(negedge clk);
        bus_idle();
        halt_par = par_m;
        check("halt_rise", {cpu_halt, dma_active, dma_done}, 3'b110);
        exp_len = 513;
`ifdef PPU_OAM_DMA_ALIGN_EN
        if (!halt_par) exp_len = 514;
`endif
        while (cpu_halt && len < 1000) begin
            len++;
            if (dma_done) done_n++;
            if (!dma_wn) begin
                if (dma_addr != 16'h2004 || dma_wdata != mem_val({page, wr_n[7:0]})) wr_bad++;
                wr_n++;
            end else if (dma_addr != 16'h0000) begin
                if (!seen_rd) begin
                    first_rd_par = par_m;
                    first_rd_len = len;
                end
                seen_rd = 1;
                if (dma_addr != {page, rd_n[7:0]}) rd_bad++;
                rd_n++;
            end
            if (inject && len == 60) bus_trig(8'hA5);
            if (inject && len == 61) bus_idle();
            if (abort_wr > 0 && wr_n == abort_wr) break;
            @(negedge clk);
        end
        if (abort_wr > 0) begin
            check("abort_rd_bad", rd_bad, 0);
            check("abort_wr_bad", wr_bad, 0);
            $display("xfer page=%02h aborted after wr=%0d", page, wr_n);
            return;
        end
        check("halt_len", len, exp_len);
        check("rd_count", rd_n, 256);
        check("wr_count", wr_n, 256);
        check("rd_addr_bad", rd_bad, 0);
        check("wr_data_bad", wr_bad, 0);
        check("done_during", done_n, 0);
        check("end_outs", {dma_done, cpu_halt, dma_active, dma_addr, dma_wn}, {3'b100, 16'h0000, 1'b1});
`ifdef PPU_OAM_DMA_ALIGN_EN
        check("first_rd_par", first_rd_par, 1'b0);
        check("first_rd_pos", first_rd_len, (exp_len == 514) ? 3 : 2);
`endif
        $display("xfer page=%02h halt_par=%0d len=%0d rd=%0d wr=%0d first_rd=%0d",
                 page, halt_par, len, rd_n, wr_n, first_rd_len);
        if (chain) begin
            bus_trig(chain_page);
        end else begin
            @(negedge clk);
            check("done_drop", {dma_done, cpu_halt}, 2'b00);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn = 1'b0;
        bus_idle();
        #23;
        check_reset_outs("reset_outs");
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outs("idle_outs");

        // A read of $4014 and a write to $4015 must not start a transfer.
        bus_addr = 16'h4014; bus_wn = 1'b1; bus_wdata = 8'h02;
        @(negedge clk);
        bus_idle();
        check("no_trig_read", cpu_halt, 1'b0);
        bus_addr = 16'h4015; bus_wn = 1'b0; bus_wdata = 8'h02;
        @(negedge clk);
        bus_idle();
        check("no_trig_4015", cpu_halt, 1'b0);

        run_xfer(8'h02, 1'b1, 1'b0, 1'b0, 0, 1'b0, 8'h00);
        run_xfer(8'h02, 1'b0, 1'b0, 1'b0, 0, 1'b0, 8'h00);
        run_xfer(8'hFF, 1'b1, 1'b0, 1'b0, 0, 1'b1, 8'h03);
        run_xfer(8'h03, 1'b0, 1'b1, 1'b0, 0, 1'b0, 8'h00);
        run_xfer(8'h05, 1'b0, 1'b0, 1'b1, 0, 1'b0, 8'h00);

        run_xfer(8'h07, 1'b1, 1'b0, 1'b0, 100, 1'b0, 8'h00);
        @(negedge clk);
        check("abort_busy", cpu_halt, 1'b1);
        rstn = 1'b0;
        #1;
        check_reset_outs("abort_reset_outs");
        @(negedge clk);
        check_reset_outs("abort_reset_hold");
        rstn = 1'b1;
        @(negedge clk);
        check_reset_outs("abort_release");
        run_xfer(8'h08, 1'b0, 1'b0, 1'b0, 0, 1'b0, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ppu_oam_dma.md
# ppu_oam_dma

OAM DMA controller for the PPU sprite memory. A CPU write to $4014 starts a transfer: the block halts the CPU, takes the system bus, and copies page $XX00–$XXFF to OAM. It does this with 256 read/write pairs, each write targeting $2004 so that the PPU register block's OAMDATA path performs the store and post-increments OAMADDR. It sits beside the CPU core; an external bus mux selects the DMA master while `o_dma_active` is high.

## Interface
Parameters: none.
- `i_cpu_clk`  in  1  CPU bus clock; one bus cycle per rising edge.
- `i_cpu_rstn`  in  1  reset; asynchronous, active-low.
- `i_bus_addr`  in  16  CPU-driven bus address, snooped for the $4014 trigger.
- `i_bus_wn`  in  1  CPU write strobe, active-low.
- `i_bus_wdata`  in  8  CPU write data; carries the source page on the trigger.
- `i_bus_rdata`  in  8  system read-data mux; valid combinationally in the same cycle as the address.
- `o_dma_addr`  out  16  DMA bus address.
- `o_dma_wn`  out  1  DMA write strobe, active-low.
- `o_dma_wdata`  out  8  DMA write data.
- `o_dma_active`  out  1  bus ownership select for the external mux; 1 means the DMA drives the bus.
- `o_cpu_halt`  out  1  CPU RDY-low request.
- `o_dma_done`  out  1  one-cycle pulse after the final write.

## Operation
- Trigger: `i_bus_addr==16'h4014 & ~i_bus_wn` while in IDLE.
  - Latch `r_page <= i_bus_wdata`.
  - Clear `r_idx`.
  - Go to HALT.
- Triggers seen in any state other than IDLE are ignored.
- Parity flag `r_par`:
  - Reset to 0; toggles every clock, free-running.
  - A cycle with `r_par==0` is even.
  - The first RD of a transfer must fall on an even cycle.
- States and transitions:
  - IDLE: wait for the trigger.
  - HALT: one dummy cycle. Go to RD if `r_par==1`; otherwise go to ALIGN.
  - ALIGN: one dummy cycle, then RD.
  - RD:
    - Drive `o_dma_addr={r_page,r_idx}`, `o_dma_wn=1`.
    - Capture `r_data <= i_bus_rdata` at the end of the cycle.
    - Go to WR.
  - WR:
    - Drive `o_dma_addr=16'h2004`, `o_dma_wn=0`, `o_dma_wdata=r_data`.
    - If `r_idx==8'hFF`: go to IDLE and pulse `o_dma_done`.
    - Otherwise: `r_idx <= r_idx+1`, then go to RD.
- `r_idx` is 8-bit and does not wrap into the next page; a transfer ends after exactly 256 writes.
- Signals by state:
  - `o_dma_active` and `o_cpu_halt` are 1 in every state except IDLE.
  - In IDLE, HALT and ALIGN: `o_dma_addr=0`, `o_dma_wn=1`, `o_dma_wdata=0`.
- OAM destination = the OAMADDR value at trigger time; increments and wrap are owned by the register block.

## Timing
- Reset values:
  - State IDLE; `r_par=0`, `r_page=0`, `r_idx=0`, `r_data=0`.
  - Outputs: `o_dma_addr=16'h0000`, `o_dma_wn=1`, `o_dma_wdata=0`, `o_dma_active=0`, `o_cpu_halt=0`, `o_dma_done=0`.
- All outputs are decoded from registered state; no input-to-output combinational path.
- Trigger write in cycle T: `o_cpu_halt` and `o_dma_active` go high in T+1 (HALT).
- Halt length: 513 cycles (HALT + 512) or 514 cycles (with ALIGN).
- Last WR in cycle L:
  - `o_cpu_halt` and `o_dma_active` go low in L+1.
  - `o_dma_done` is high only in L+1.
- The CPU may issue a new trigger in L+1; it is accepted.
- Reset mid-transfer: immediate return to IDLE with all outputs at reset values. The partially written OAM is not restored.

## Configuration
- `PPU_OAM_DMA_ALIGN_EN` defined:
  - Parity alignment as described; the ALIGN state exists.
  - 513/514-cycle halt.
- Not defined:
  - `r_par` and ALIGN are removed; HALT always goes to RD.
  - Halt is always 513 cycles.

## Test plan
- Reset, write $4014=8'h02 with HALT landing on `r_par==1`:
  - RD addresses $0200..$02FF in order.
  - 256 WR cycles at $2004 whose data equals memory[$0200+n].
  - Halt lasts 513 cycles; `o_dma_done` pulses once.
- Same trigger with HALT landing on `r_par==0`, macro defined:
  - One ALIGN cycle; halt lasts 514 cycles; first RD occurs with `r_par==0`.
- Same trigger, macro undefined: halt is 513 cycles regardless of parity.
- Page $FF: last RD address $FFFF, then IDLE; no access to $0000.
- Force a $4014 write on `i_bus_addr` during the transfer: `r_page` and `r_idx` are unchanged and the transfer completes normally.
- Deassert `i_cpu_rstn` after write 100:
  - All outputs return to reset values immediately.
  - After reset release, a new trigger runs a full 256-write transfer.
